proc_run_controller: RTL

Synthesizable run controller that drives the single-cycle processor the way a bench does: it resets the core at a chosen start PC, lets it run until the PC reaches an end address, waits one cycle for the pass code to appear on the data-memory read port, and compares that code against an expected value. Pass and total test counts and a watchdog timeout are kept in hardware. The block sits beside `SingleCycleProc` (or an FPGA wrapper of it) and owns the core's reset and start-PC inputs.

---
 rtl/proc_run_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/proc_run_controller.sv
// Run controller for the single-cycle core: resets it at a start PC, runs to an end PC,
// then checks the pass code on the data-memory port. Optional watchdog: PROC_RUN_WDOG_EN.
module proc_run_controller #(
  parameter int RESET_CYCLES = 1,
  parameter int WDOG_WIDTH   = 16
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        start,
  input  logic [63:0] startPCIn,
  input  logic [63:0] endPC,
  input  logic [63:0] expectedCode,
  input  logic        clrCounts,
  input  logic [63:0] currentPC,
  input  logic [63:0] dMemOut,
  output logic        procResetL,
  output logic [63:0] procStartPC,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [7:0]  passCount,
  output logic [7:0]  testCount
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     start_pc_q, start_pc_d;
  logic [63:0]     end_pc_q, end_pc_d;
  logic [63:0]     code_q, code_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic            proc_rst_l_q, proc_rst_l_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      pass_cnt_q, pass_cnt_d;
  logic [7:0]      test_cnt_q, test_cnt_d;
  logic            pc_reached;

`ifdef PROC_RUN_WDOG_EN
  logic [WDOG_WIDTH-1:0] wdog_q, wdog_d;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign pc_reached = (currentPC >= end_pc_q);

  always_comb begin
    state_d      = state_q;
    start_pc_d   = start_pc_q;
    end_pc_d     = end_pc_q;
    code_d       = code_q;
    rst_cnt_d    = rst_cnt_q;
    proc_rst_l_d = proc_rst_l_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    pass_cnt_d   = pass_cnt_q;
    test_cnt_d   = test_cnt_q;
`ifdef PROC_RUN_WDOG_EN
    wdog_d       = wdog_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          start_pc_d   = startPCIn;
          end_pc_d     = endPC;
          code_d       = expectedCode;
          rst_cnt_d    = '0;
          proc_rst_l_d = 1'b0;
          state_d      = RESET;
`ifdef PROC_RUN_WDOG_EN
          wdog_d       = '0;
`endif
        end
      end
      RESET: begin
        if (rst_cnt_q == RC_LAST) begin
          proc_rst_l_d = 1'b1;
          state_d      = RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      RUN: begin
        // End-PC takes priority over a watchdog expiring on the same edge.
        if (pc_reached) begin
          state_d = SETTLE;
        end
`ifdef PROC_RUN_WDOG_EN
        else if (&wdog_q) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      SETTLE: state_d = CHECK;
      CHECK: begin
        pass_d    = (dMemOut == code_q);
        timeout_d = 1'b0;
        state_d   = DONE;
      end
      DONE: begin
        test_cnt_d = sat_inc(test_cnt_q);
        if (pass_q) pass_cnt_d = sat_inc(pass_cnt_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clrCounts) begin
      pass_cnt_d = 8'd0;
      test_cnt_d = 8'd0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q      <= IDLE;
      start_pc_q   <= '0;
      end_pc_q     <= '0;
      code_q       <= '0;
      rst_cnt_q    <= '0;
      proc_rst_l_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      pass_cnt_q   <= '0;
      test_cnt_q   <= '0;
`ifdef PROC_RUN_WDOG_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      start_pc_q   <= start_pc_d;
      end_pc_q     <= end_pc_d;
      code_q       <= code_d;
      rst_cnt_q    <= rst_cnt_d;
      proc_rst_l_q <= proc_rst_l_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      pass_cnt_q   <= pass_cnt_d;
      test_cnt_q   <= test_cnt_d;
`ifdef PROC_RUN_WDOG_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign procResetL  = proc_rst_l_q;
  assign procStartPC = start_pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign passCount   = pass_cnt_q;
  assign testCount   = test_cnt_q;

endmodule
